// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
//   Shared definitions for the FIFO drain sequencer: the FSM state encoding
//   (also exported on the debug 'state' port) and helpers that derive the
//   beat count and the beat-counter width from the word and beat widths.
package fifo_drain_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SEND     = 3'd2,
    WAIT_FIN = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Beats per FIFO word. DATA_W is expected to be an integer multiple of OUT_W.
  function automatic int unsigned beats_of(input int unsigned data_w,
                                           input int unsigned out_w);
    return (out_w == 0) ? 1 : (data_w / out_w);
  endfunction

  // Width of a counter indexing 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_beat_shifter.sv
// fifo_drain_beat_shifter
//   Holds the word popped from the FIFO and presents it one OUT_W beat at a
//   time, most significant beat first.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture din and restart the beat index
//   shift       advance to the next beat
//   din         FIFO word (DATA_W)
//   beat        current beat, top OUT_W bits of the held word
//   last_beat   high while the current beat is the final one of the word
module fifo_drain_beat_shifter
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [OUT_W-1:0]  beat,
  output logic              last_beat
);

  localparam int unsigned BEATS = beats_of(DATA_W, OUT_W);
  localparam int unsigned CNT_W = cnt_w_of(BEATS);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  beat_cnt;

  // With a single beat per word there is nothing to shift in from below.
  if (BEATS > 1) begin : g_multi
    assign shift_nxt = {shift_q[DATA_W-OUT_W-1:0], {OUT_W{1'b0}}};
  end else begin : g_single
    assign shift_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      shift_q  <= din;
      beat_cnt <= '0;
    end else if (shift) begin
      shift_q  <= shift_nxt;
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  assign beat      = shift_q[DATA_W-1 -: OUT_W];
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/fifo_drain_seq.sv
// fifo_drain_seq
//   Drains a show-ahead FIFO into a beat-wide sender. Each popped word is
//   split into DATA_W/OUT_W beats (MSB first); every beat uses an
//   out_start/out_finish level handshake. Bursts are either burst_len words
//   or, with burst_len = 0, run until enable drops. Dropping enable never
//   truncates a word: the burst stops at the next word boundary.
//   Optional sender watchdog: define FIFO_DRAIN_TIMEOUT_EN. Without it the
//   sequencer waits for out_finish forever and err stays 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            level request to run a burst
//   burst_len         words per burst, 0 = stream while enable is high
//   fifo_busy         FIFO cannot be popped this cycle
//   fifo_empty        FIFO has no word
//   fifo_data         FIFO head word
//   fifo_re           one-cycle pop pulse
//   out_data          current beat to the sender
//   out_start         beat request, held until out_finish
//   out_finish        sender completed the beat
//   busy              burst in progress
//   done              burst completed, held until enable drops
//   word_count        words fully sent in the current burst (saturating)
//   err               sticky watchdog error
//   state             FSM state for debug
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for enable; burst parameters latched on entry to run
// FETCH    | waiting for a poppable FIFO word; abort if enable drops
// SEND     | pop pulse active; present the next beat to the sender
// WAIT_FIN | out_start held until out_finish (or watchdog expiry)
// GAP      | out_start low one cycle; next beat or word-boundary decision
// DONE     | burst finished; hold done until enable drops
module fifo_drain_seq
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              fifo_busy,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_re,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_start,
  input  logic              out_finish,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  word_count,
  output logic              err,
  output logic [2:0]        state
);

  state_t           st;
  logic [LEN_W-1:0] len_q;
  logic             pop_ok;
  logic             sh_shift;
  logic [OUT_W-1:0] beat;
  logic             last_beat;
  logic             tmr_expired;
  logic [LEN_W-1:0] wc_inc;
  logic [LEN_W:0]   wc_plus1;

  assign state    = st;
  assign pop_ok   = (st == FETCH) && enable && !fifo_busy && !fifo_empty;
  assign sh_shift = (st == GAP) && !last_beat;

  // One extra bit so the burst-length compare stays exact at the top of range.
  assign wc_plus1 = {1'b0, word_count} + (LEN_W+1)'(1);
  assign wc_inc   = (word_count == '1) ? word_count : wc_plus1[LEN_W-1:0];

  fifo_drain_beat_shifter #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pop_ok),
    .shift     (sh_shift),
    .din       (fifo_data),
    .beat      (beat),
    .last_beat (last_beat)
  );

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // Down-counter loaded as out_start rises; expiry on its terminal count
  // leaves out_start high for exactly TIMEOUT_CYC cycles.
  logic [TMR_W-1:0] tmr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else if (st == SEND) begin
      tmr_q <= TMR_W'(TIMEOUT_CYC - 1);
    end else if ((st == WAIT_FIN) && (tmr_q != '0)) begin
      tmr_q <= tmr_q - TMR_W'(1);
    end
  end

  assign tmr_expired = (st == WAIT_FIN) && !out_finish && (tmr_q == '0);
`else
  // No watchdog: WAIT_FIN waits indefinitely and err can never be set.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign tmr_expired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      len_q      <= '0;
      fifo_re    <= 1'b0;
      out_data   <= '0;
      out_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      fifo_re <= 1'b0;
      case (st)
        IDLE: begin
          if (enable) begin
            len_q      <= burst_len;
            word_count <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            st         <= FETCH;
          end
        end
        FETCH: begin
          if (!enable) begin
            busy <= 1'b0;
            st   <= IDLE;
          end else if (pop_ok) begin
            fifo_re <= 1'b1;
            st      <= SEND;
          end
        end
        SEND: begin
          out_data  <= beat;
          out_start <= 1'b1;
          st        <= WAIT_FIN;
        end
        WAIT_FIN: begin
          if (out_finish) begin
            out_start <= 1'b0;
            st        <= GAP;
          end else if (tmr_expired) begin
            out_start <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            st        <= DONE;
          end
        end
        GAP: begin
          if (!last_beat) begin
            st <= SEND;
          end else begin
            word_count <= wc_inc;
            if ((len_q != '0) && (wc_plus1 == {1'b0, len_q})) begin
              busy <= 1'b0;
              done <= 1'b1;
              st   <= DONE;
            end else if (!enable) begin
              busy <= 1'b0;
              st   <= IDLE;
            end else begin
              st <= FETCH;
            end
          end
        end
        DONE: begin
          if (!enable) begin
            done <= 1'b0;
            st   <= IDLE;
          end
        end
        default: begin
          out_start <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          st        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_seq.sv
// Bench for fifo_drain_seq (default build, watchdog compiled out).
// The bench owns the FIFO contents and a sender model. A scoreboard queue of
// expected beats is filled from each popped word (split MSB-first) and every
// cycle the DUT outputs are checked against handshake and burst rules.
module tb_fifo_drain_seq;

  localparam int DATA_W = 16;
  localparam int OUT_W  = 8;
  localparam int LEN_W  = 8;
  localparam int BEATS  = DATA_W / OUT_W;
  localparam int WC_MAX = (1 << LEN_W) - 1;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              enable     = 1'b0;
  logic [LEN_W-1:0]  burst_len  = '0;
  logic              fifo_busy  = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data  = '0;
  logic              fifo_re;
  logic [OUT_W-1:0]  out_data;
  logic              out_start;
  logic              out_finish = 1'b0;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  word_count;
  logic              err;
  logic [2:0]        state;

  always #5 clk = ~clk;

  fifo_drain_seq #(
    .DATA_W      (DATA_W),
    .OUT_W       (OUT_W),
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .burst_len  (burst_len),
    .fifo_busy  (fifo_busy),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .out_data   (out_data),
    .out_start  (out_start),
    .out_finish (out_finish),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .err        (err),
    .state      (state)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FIFO and sender model state
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] push_q[$];
  logic [OUT_W-1:0]  beat_q[$];
  logic [OUT_W-1:0]  obs_q[$];
  int  re_cnt   = 0;
  int  fin_mode = 0;     // 0 random delay, 1 never finish, 2 immediate
  bit  spur_en  = 1'b0;  // spurious out_finish while out_start is low

  // Previous-sample values: what the DUT saw at the edge just passed.
  logic start_p, re_p, busy_p, done_p, en_p, fb_p, fe_p, real_fin_p;
  logic [OUT_W-1:0] data_p;
  logic [LEN_W-1:0] len_p;
  int  beat_pos, wc_model, target, fin_delay;
  bit  word_end_pending;

  initial begin
    logic [DATA_W-1:0] w;
    bit in_word, real_fin_now;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beat_q.delete();
        beat_pos = 0; wc_model = 0; target = 0; fin_delay = 0;
        word_end_pending = 1'b0;
        out_finish = 1'b0;
        start_p = 0; re_p = 0; busy_p = 0; done_p = 0; real_fin_p = 0;
        data_p = '0;
      end else begin
        // Word completed on the previous cycle: count it and check the
        // boundary decision (done, abort, or continue).
        if (word_end_pending) begin
          word_end_pending = 1'b0;
          if (wc_model < WC_MAX) wc_model++;
          if (target != 0 && wc_model == target) begin
            check("done_at_len", done, 1);
            check("busy_at_len", busy, 0);
          end else if (!en_p) begin
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
          end else begin
            check("continue_busy", busy, 1);
          end
        end else if (busy_p && !busy && !done) begin
          check("fetch_abort", {en_p, beat_q.size() != 0, beat_pos != 0}, 3'b000);
        end
        if (busy && !busy_p && !done_p) begin
          check("start_needs_en", en_p, 1);
          wc_model = 0;
          target = int'(len_p);
        end
        check("word_count", word_count, wc_model);
        check("err_zero", err, 0);
        check("busy_done_excl", busy & done, 0);
        if (done_p) check("done_hold", done, en_p);

        if (fifo_re) begin
          in_word = (beat_q.size() != 0) || (beat_pos != 0);
          check("pop_gate", {re_p, fb_p, fe_p, out_start, in_word, en_p, busy}, 7'b0000011);
          if (fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            for (int b = 0; b < BEATS; b++) beat_q.push_back(w[DATA_W-1-b*OUT_W -: OUT_W]);
          end
          re_cnt++;
        end

        if (out_start && !start_p) begin
          check("rise_busy", busy, 1);
          check("beat_avail", beat_q.size() > 0, 1);
          check("pop_to_start", re_p, beat_pos == 0);
          if (beat_q.size() > 0) check("beat_data", out_data, beat_q.pop_front());
          obs_q.push_back(out_data);
          fin_delay = (fin_mode == 2) ? 0 : int'($urandom_range(0, 3));
        end
        if (out_start && start_p) check("data_hold", out_data, data_p);
        if (start_p) check("finish_handshake", !out_start, real_fin_p);
        if (start_p && !out_start) begin
          beat_pos++;
          if (beat_pos == BEATS) begin
            beat_pos = 0;
            word_end_pending = 1'b1;
          end
        end

        // Sender
        real_fin_now = 1'b0;
        if (out_finish) out_finish = 1'b0;
        else if (out_start) begin
          if (fin_mode != 1) begin
            if (fin_delay == 0) begin
              out_finish = 1'b1;
              real_fin_now = 1'b1;
            end else fin_delay--;
          end
        end else if (spur_en && $urandom_range(0, 3) == 0) out_finish = 1'b1;
        real_fin_p = real_fin_now;

        start_p = out_start; data_p = out_data; re_p = fifo_re;
        busy_p = busy; done_p = done;
      end
      en_p = enable; fb_p = fifo_busy; len_p = burst_len;
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? '0 : fifo_q[0];
      fe_p = fifo_empty;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int kind, input int arg);
    case (kind)
      0: return done == 1'b1;
      1: return busy == 1'b0 && done == 1'b0;
      2: return out_start == 1'b1;
      3: return int'(word_count) == arg;
      default: return fifo_q.size() == 0 && push_q.size() == 0 && state == 3'd1;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int kind, input int arg, input int max_cyc);
    int n = 0;
    while (!cond(kind, arg) && n < max_cyc) begin
      cyc(1);
      n++;
    end
    n_chk++;
    if (!cond(kind, arg)) begin
      n_fail++;
      $display("FAIL wait_%s: condition not reached within %0d cycles", nm, max_cyc);
    end
  endtask

  function automatic logic [15:0] obs_at(input int i);
    return (i < obs_q.size()) ? {8'h00, obs_q[i]} : 16'hFFFF;
  endfunction

  initial begin
    logic [DATA_W-1:0] rw;
    int len, cycles, lim, pushed;
    bit dropped;

    cyc(3);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fifo_re", fifo_re, 0);
    check("rst_out_start", out_start, 0);
    check("rst_out_data", out_data, 0);
    check("rst_word_count", word_count, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    cyc(2);

    // Two-word burst, two beats each
    spur_en = 1'b1; fin_mode = 0;
    push_q.push_back(16'hA1B2); push_q.push_back(16'hC3D4);
    cyc(2);
    obs_q.delete(); re_cnt = 0;
    burst_len = 8'd2; enable = 1'b1;
    wait_for("t1_done", 0, 0, 200);
    check("t1_done", done, 1);
    check("t1_word_count", word_count, 2);
    check("t1_pops", re_cnt, 2);
    check("t1_beat0", obs_at(0), 16'h00A1);
    check("t1_beat1", obs_at(1), 16'h00B2);
    check("t1_beat2", obs_at(2), 16'h00C3);
    check("t1_beat3", obs_at(3), 16'h00D4);
    enable = 1'b0;
    cyc(2);
    check("t1_done_clear", done, 0);
    check("t1_idle", state, 0);

    // Empty FIFO: hold in FETCH without popping, then one late word
    obs_q.delete(); re_cnt = 0;
    burst_len = 8'd3; enable = 1'b1;
    cyc(20);
    check("t2_fetch_hold", state, 1);
    check("t2_no_pop", re_cnt, 0);
    check("t2_busy", busy, 1);
    push_q.push_back(16'h5A6B);
    wait_for("t2_word", 3, 1, 100);
    cyc(2);
    check("t2_one_pop", re_cnt, 1);
    check("t2_busy_after", busy, 1);
    check("t2_back_fetch", state, 1);
    check("t2_beat0", obs_at(0), 16'h005A);
    check("t2_beat1", obs_at(1), 16'h006B);
    enable = 1'b0;
    cyc(2);
    check("t2_abort_busy", busy, 0);
    check("t2_abort_done", done, 0);
    check("t2_abort_wc", word_count, 1);

    // Enable dropped during beat 1: the word still completes
    push_q.push_back(16'h1122); push_q.push_back(16'h3344);
    cyc(2);
    obs_q.delete();
    burst_len = 8'd0; enable = 1'b1;
    wait_for("t3_start", 2, 0, 100);
    enable = 1'b0;
    wait_for("t3_idle", 1, 0, 100);
    check("t3_word_count", word_count, 1);
    check("t3_done", done, 0);
    check("t3_beat0", obs_at(0), 16'h0011);
    check("t3_beat1", obs_at(1), 16'h0022);
    check("t3_fifo_left", fifo_q.size(), 1);

    // fifo_busy blocks the pop while data is waiting
    obs_q.delete(); re_cnt = 0;
    fifo_busy = 1'b1; burst_len = 8'd1; enable = 1'b1;
    cyc(5);
    check("t4_no_pop_busy", re_cnt, 0);
    check("t4_fetch", state, 1);
    fifo_busy = 1'b0;
    wait_for("t4_done", 0, 0, 100);
    check("t4_one_pop", re_cnt, 1);
    check("t4_word_count", word_count, 1);
    check("t4_beat0", obs_at(0), 16'h0033);
    enable = 1'b0;
    cyc(2);

    // Asynchronous reset while waiting for the sender
    fin_mode = 1;
    push_q.push_back(16'hBEEF);
    burst_len = 8'd1; enable = 1'b1;
    wait_for("t5_start", 2, 0, 100);
    cyc(3);
    check("t5_wait_fin", state, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out_start", out_start, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_wc", word_count, 0);
    check("t5_rst_state", state, 0);
    enable = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    fin_mode = 0;
    cyc(2);

    // Randomized bursts
    for (int it = 0; it < 30; it++) begin
      len = int'($urandom_range(0, 4));
      fin_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      spur_en = $urandom_range(0, 1) == 1;
      burst_len = LEN_W'(len);
      lim = int'($urandom_range(20, 120));
      pushed = 0; cycles = 0; dropped = 1'b0;
      enable = 1'b1;
      while (cycles < 400) begin
        if (pushed < len + 2 && $urandom_range(0, 2) == 0) begin
          rw = DATA_W'($urandom);
          push_q.push_back(rw);
          pushed++;
        end
        fifo_busy = ($urandom_range(0, 3) == 0);
        if (len == 0 && cycles >= lim) enable = 1'b0;
        if (len != 0 && $urandom_range(0, 59) == 0) begin
          enable = 1'b0;
          dropped = 1'b1;
        end
        cyc(1);
        cycles++;
        if (done || !enable) break;
      end
      if (done && !dropped) check("rand_len_wc", word_count, len);
      enable = 1'b0;
      fifo_busy = 1'b0;
      wait_for("rand_idle", 1, 0, 200);
      cyc(2);
    end

    // Streaming word_count saturates instead of wrapping
    fin_mode = 2; spur_en = 1'b0; fifo_busy = 1'b0;
    for (int i = 0; i < WC_MAX + 5; i++) begin
      rw = DATA_W'($urandom);
      push_q.push_back(rw);
    end
    cyc(2);
    burst_len = 8'd0; enable = 1'b1;
    wait_for("sat_drain", 4, 0, 6000);
    check("sat_word_count", word_count, WC_MAX);
    enable = 1'b0;
    wait_for("sat_idle", 1, 0, 50);
    check("sat_hold", word_count, WC_MAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
